// File: rtl/mem_pkg.sv
// Shared types and helpers for the mem_bank data store.
package mem_pkg;

    typedef enum logic {IDLE, CLEAR} mem_state_t;

    // Even-parity bit: XOR of all data bits, so data plus parity has an even count of ones.
    function automatic logic par_f(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mem_word_reg.sv
// One storage word of W flops: asynchronous active-low clear, loads i_d when i_we is high.
module mem_word_reg #(
    parameter int W = 8
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (i_we)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_bank.sv
// DEPTH x WIDTH word store with valid/ready request port, registered read data and clear sweep.
// Optional MEM_BANK_PARITY_EN adds a per-word even-parity bit and the par_inj fault-injection input.
module mem_bank
    import mem_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              clr,
`ifdef MEM_BANK_PARITY_EN
    input  logic              par_inj,
`endif
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              rerr,
    output logic              busy
);

`ifdef MEM_BANK_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic [SW-1:0]     w_q [DEPTH];
    logic [SW-1:0]     w_load;
    logic [SW-1:0]     w_rd_word;
    logic [DEPTH-1:0]  w_we;
    logic              w_accept;
    logic              w_in_range;
    logic              w_clearing;
    logic              w_par_err;

    mem_state_t        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [WIDTH-1:0]  r_rdata;
    logic              r_rvalid;
    logic              r_rerr;
    logic              r_busy;

    assign req_ready  = (r_state == IDLE) && !clr;
    assign w_accept   = sel && req_valid && req_ready;
    assign w_in_range = 32'(addr) < DEPTH;
    assign w_clearing = (r_state == CLEAR);

`ifdef MEM_BANK_PARITY_EN
    assign w_load    = w_clearing ? '0 : {par_f(64'(wdata)) ^ par_inj, wdata};
    assign w_par_err = w_rd_word[SW-1] != par_f(64'(w_rd_word[WIDTH-1:0]));
`else
    assign w_load    = w_clearing ? '0 : wdata;
    assign w_par_err = 1'b0;
`endif

    // Decode only matches i < DEPTH, so out-of-range writes hit no word and reads see zero.
    always_comb begin
        w_we      = '0;
        w_rd_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_we[i] = (w_clearing && r_ptr == ADDR_W'(i)) ||
                      (w_accept && rw && addr == ADDR_W'(i));
            if (addr == ADDR_W'(i))
                w_rd_word = w_q[i];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        mem_word_reg #(.W(SW)) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .i_we  (w_we[g]),
            .i_d   (w_load),
            .o_q   (w_q[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_rerr   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_rerr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end else if (w_accept && !rw) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_in_range ? w_rd_word[WIDTH-1:0] : '0;
                        r_rerr   <= !w_in_range || w_par_err;
                    end
                end
                CLEAR: begin
                    if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign rerr   = r_rerr;
    assign busy   = r_busy;

endmodule

// File: tb/tb_mem_bank.sv
// Scoreboard bench for mem_bank (DEPTH=12 so out-of-range addresses are reachable).
// Build with +define+MEM_BANK_PARITY_EN to exercise the parity variant.
module tb_mem_bank;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 12;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef struct {
        int               due;
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sel = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              rw = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [WIDTH-1:0]  wdata = '0;
    logic              clr = 1'b0;
    logic              par_inj = 1'b0;
    logic [WIDTH-1:0]  rdata;
    logic              rvalid;
    logic              rerr;
    logic              busy;

    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    exp_t             sb[$];
    logic [WIDTH-1:0] model [DEPTH];
    logic             bad   [DEPTH];

    mem_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .clr       (clr),
`ifdef MEM_BANK_PARITY_EN
        .par_inj   (par_inj),
`endif
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rerr      (rerr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every read response must land exactly on its due cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (rvalid !== 1'b1 || rdata !== e.data || rerr !== e.err) begin
                n_err++;
                $display("FAIL read_resp: rvalid=%b rdata=%h rerr=%b, expected rvalid=1 rdata=%h rerr=%b",
                         rvalid, rdata, rerr, e.data, e.err);
            end
        end else if (rvalid !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL rvalid_spurious: rvalid=%b at cycle %0d, expected 0", rvalid, cyc);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            bad[i]   = 1'b0;
        end
    endtask

    // Drives one request for one cycle (called at a negedge, returns at the next negedge).
    task automatic issue(input logic s, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [WIDTH-1:0] d, input logic inj);
        exp_t e;
        sel = s; req_valid = 1'b1; rw = w; addr = a; wdata = d; par_inj = inj;
        if (s) begin
            if (w) begin
                if (int'(a) < DEPTH) begin
                    model[a] = d;
`ifdef MEM_BANK_PARITY_EN
                    bad[a] = inj;
`else
                    bad[a] = 1'b0;
`endif
                end
            end else begin
                e.due  = cyc + 1;
                e.data = (int'(a) < DEPTH) ? model[a] : '0;
                e.err  = (int'(a) >= DEPTH) || ((int'(a) < DEPTH) && bad[a]);
                sb.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sel = 1'b0; req_valid = 1'b0; rw = 1'b0; par_inj = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++)
            issue(1'b1, 1'b0, ADDR_W'(i), '0, 1'b0);
        idle(2);
    endtask

    task automatic fill(input logic [WIDTH-1:0] v);
        for (int i = 0; i < DEPTH; i++)
            issue(1'b1, 1'b1, ADDR_W'(i), v, 1'b0);
        idle(1);
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (rdata !== '0 || rvalid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: rdata=%h rvalid=%b busy=%b req_ready=%b, expected 00 0 0 1",
                     rdata, rvalid, busy, req_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        read_all();
    endtask

    task automatic test_write_read();
        issue(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0);
        issue(1'b1, 1'b0, 4'd3, '0, 1'b0);
        idle(2);
    endtask

    task automatic test_sel_off();
        issue(1'b0, 1'b1, 4'd3, 8'hFF, 1'b0);
        idle(1);
        issue(1'b1, 1'b0, 4'd3, '0, 1'b0);
        idle(2);
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < DEPTH; i++)
            issue(1'b1, 1'b1, ADDR_W'(i), WIDTH'(i * 17 + 1), 1'b0);
        issue(1'b1, 1'b1, 4'd13, 8'h11, 1'b0);
        issue(1'b1, 1'b0, 4'd13, '0, 1'b0);
        issue(1'b1, 1'b0, 4'd15, '0, 1'b0);
        idle(1);
        read_all();
    endtask

    task automatic start_clear(output logic [WIDTH-1:0] held);
        held = rdata;
        sel = 1'b1; req_valid = 1'b1; rw = 1'b0; addr = 4'd0; clr = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clr_ready: req_ready=%b with clr=1, expected 0", req_ready);
        end
        @(negedge clk);
        clr = 1'b0;
        idle(0);
    endtask

    task automatic test_clear();
        logic [WIDTH-1:0] held;
        int               cnt;
        fill(8'h5A);
        issue(1'b1, 1'b0, 4'd7, '0, 1'b0);
        idle(2);
        start_clear(held);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            n_vec++;
            if (req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL sweep_ready: req_ready=%b during sweep, expected 0", req_ready);
            end
            @(negedge clk);
        end
        n_vec++;
        if (cnt != DEPTH) begin
            n_err++;
            $display("FAIL sweep_len: busy cycles=%0d, expected %0d", cnt, DEPTH);
        end
        n_vec++;
        if (rdata !== held) begin
            n_err++;
            $display("FAIL sweep_rdata: rdata=%h after sweep, expected held %h", rdata, held);
        end
        model_reset();
        read_all();

        fill(8'h5A);
        start_clear(held);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || rdata !== '0) begin
            n_err++;
            $display("FAIL sweep_reset: busy=%b req_ready=%b rdata=%h, expected 0 1 00",
                     busy, req_ready, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_all();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom_range(DEPTH - 1, 0));
            n_vec++;
            if (req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready: req_ready=%b, expected 1", req_ready);
            end
            issue(1'b1, 1'b1, a, WIDTH'($urandom), 1'b0);
            issue(1'b1, 1'b0, a, '0, 1'b0);
        end
        idle(2);
    endtask

    task automatic test_parity();
`ifdef MEM_BANK_PARITY_EN
        issue(1'b1, 1'b1, 4'd2, 8'h07, 1'b1);
        issue(1'b1, 1'b0, 4'd2, '0, 1'b0);
        issue(1'b1, 1'b1, 4'd2, 8'h07, 1'b0);
        issue(1'b1, 1'b0, 4'd2, '0, 1'b0);
        idle(2);
`endif
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_write_read();
                test_sel_off();
                test_out_of_range();
                test_clear();
                test_back_to_back();
                test_parity();
                idle(3);
            end
            begin
                #200000;
                n_err++;
                $display("FAIL timeout: simulation exceeded time budget");
            end
        join_any
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL pending_reads: %0d responses never seen, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
